// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Optional PC_SEQ_PERF_EN adds performance counters to pc_sequencer.
package pc_seq_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } seq_state_e;

  // Redirect targets are forced to word alignment before use.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return t & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the EX load and ID sources.
module load_use_detect
  import pc_seq_pkg::*;
(
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              luh
);

  logic rd_nonzero;
  logic src_match;

  assign rd_nonzero = (ex_rd != REG_AW'(0));
  assign src_match  = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign luh        = ex_mem_read && rd_nonzero && src_match;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential advance, load-use stalls and EX redirects,
// holding redirects while a fetch is in flight. PC_SEQ_PERF_EN adds counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic [XLEN-1:0]   pc,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_flush
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       redirect_count
`endif
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic [XLEN-1:0] target;
  logic            luh;

  assign target = align_target(ex_target);
  assign pc     = pc_q;

  load_use_detect u_luh (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .luh         (luh)
  );

  // State, PC and pending-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pending_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

  // Next state, next PC and pipeline controls; reset suppresses all controls.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (imem_ready) begin
              pc_d = target;
            end else begin
              pending_d = target;
              state_d   = WAIT;
            end
          end else if (luh) begin
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (imem_ready) begin
            pc_d = pc_q + PC_STEP;
          end
        end
        WAIT: begin
          // ID holds a flushed slot here, so load-use is irrelevant.
          ifid_flush = 1'b1;
          if (ex_redirect) begin
            pending_d = target;
          end
          if (imem_ready) begin
            pc_d    = ex_redirect ? target : pending_q;
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic luh_taken;
  logic redirect_taken;

  assign luh_taken      = (state_q == RUN) && !ex_redirect && luh;
  assign redirect_taken = ex_redirect;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= 32'h0;
      redirect_count <= 32'h0;
    end else begin
      if (luh_taken) begin
        stall_cycles <= stall_cycles + 32'h1;
      end
      if (redirect_taken) begin
        redirect_count <= redirect_count + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: reference model plus directed checks.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read;
  logic [31:0] pc;
  logic        ifid_stall, ifid_flush, idex_flush;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] stall_cycles, redirect_count;
`endif

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_ready  (imem_ready),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .pc          (pc),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush)
`ifdef PC_SEQ_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: fetch address, whether a redirect is parked, and its target.
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_wait;
  bit          m_valid = 1'b0;

  function automatic bit hazard();
    return ex_mem_read && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  // Expected {ifid_stall, ifid_flush, idex_flush} for the current cycle.
  function automatic logic [2:0] exp_ctl();
    if (rst)         return 3'b000;
    if (m_wait)      return 3'b010;
    if (ex_redirect) return 3'b011;
    if (hazard())    return 3'b101;
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc    = 32'h0;
      m_wait  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_wait) begin
        if (ex_redirect) m_pend = {ex_target[31:2], 2'b00};
        if (imem_ready) begin
          m_pc   = m_pend;
          m_wait = 1'b0;
        end
      end else if (ex_redirect) begin
        if (imem_ready) m_pc = {ex_target[31:2], 2'b00};
        else begin
          m_pend = {ex_target[31:2], 2'b00};
          m_wait = 1'b1;
        end
      end else if (!hazard() && imem_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pc", pc, m_pc);
      chk("model_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, {29'd0, exp_ctl()});
    end
  end

  task automatic drive(input bit r, input bit rdy, input bit redir, input logic [31:0] tgt,
                       input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    rst = r; imem_ready = rdy; ex_redirect = redir; ex_target = tgt;
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input bit rdy);
    drive(0, rdy, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  int flush_cnt;

  initial begin
    drive(1, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'h0);

    // Sequential advance.
    for (int i = 1; i <= 4; i++) begin
      seq(1);
      chk("adv_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'h0);
      tick();
      chk("adv_pc", pc, 32'(4 * i));
    end
    for (int i = 0; i < 4; i++) begin seq(1); tick(); end
    chk("pc_0x20", pc, 32'h20);

    // Redirect accepted immediately; target misaligned by 3.
    drive(0, 1, 1, 32'h103, 0, 5'd0, 5'd0, 5'd0);
    chk("redir_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'b011);
    tick();
    chk("redir_pc", pc, 32'h100);

    drive(0, 1, 1, 32'h24, 0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("pc_0x24", pc, 32'h24);

    // Redirect under an outstanding fetch.
    flush_cnt = 0;
    drive(0, 0, 1, 32'h80, 0, 5'd0, 5'd0, 5'd0);
    if (ifid_flush) flush_cnt++;
    tick();
    chk("wait_hold0", pc, 32'h24);
    for (int i = 0; i < 2; i++) begin
      seq(0);
      if (ifid_flush) flush_cnt++;
      tick();
      chk("wait_hold", pc, 32'h24);
    end
    seq(1);
    if (ifid_flush) flush_cnt++;
    tick();
    chk("wait_flush_cnt", 32'(flush_cnt), 32'd4);
    chk("wait_pc", pc, 32'h80);

    // Load-use on rs2, then the load leaves EX.
    drive(0, 1, 0, 32'h0, 1, 5'd5, 5'd1, 5'd5);
    chk("luh_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'b101);
    tick();
    chk("luh_pc", pc, 32'h80);
    seq(1);
    chk("luh_clear", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'h0);
    tick();
    chk("luh_adv", pc, 32'h84);
    drive(0, 1, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
    chk("x0_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'h0);
    tick();
    chk("x0_pc", pc, 32'h88);

    // Redirect beats load-use; second redirect in WAIT wins.
    drive(0, 0, 1, 32'h300, 1, 5'd7, 5'd7, 5'd2);
    chk("prio_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'b011);
    tick();
    drive(0, 0, 1, 32'h200, 1, 5'd7, 5'd7, 5'd2);
    chk("wait_luh_ign", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'b010);
    tick();
    seq(1);
    tick();
    chk("last_wins", pc, 32'h200);

    // Redirect arriving on the same cycle the fetch returns.
    drive(0, 0, 1, 32'h400, 0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(0, 1, 1, 32'h404, 0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("same_cycle", pc, 32'h404);

    // Wrap at the top of the address space.
    drive(0, 1, 1, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    seq(1);
    tick();
    chk("wrap_pc", pc, 32'h0);

    // Reset while a redirect is pending.
    drive(0, 0, 1, 32'h500, 0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1, 1, 1, 32'h600, 1, 5'd3, 5'd3, 5'd3);
    chk("rst_ctl", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'h0);
    tick();
    chk("rst_wait_pc", pc, 32'h0);
    seq(0);
    chk("rst_run", {29'd0, ifid_stall, ifid_flush, idex_flush}, 32'h0);
    tick();
    seq(1);
    tick();
    chk("post_rst_adv", pc, 32'h4);

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      tick();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the fetch program counter of the pipelined RV32I core and sequences it against three sources: sequential advance, load-use hazards, and taken redirects resolved in EX by the branch/jump PC-update logic. Also generates the stall/flush controls for the IF/ID and ID/EX pipeline registers. Holds a pending redirect when the instruction memory has a fetch in flight, so the PC never changes under an outstanding request.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- imem_ready  in  1  instruction memory accepted/returned the fetch at `pc` this cycle.
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr this cycle.
- ex_target  in  32  redirect target; valid with `ex_redirect`.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- pc  out  32  current fetch address (registered).
- ifid_stall  out  1  hold the IF/ID register.
- ifid_flush  out  1  zero the IF/ID register (insert NOP).
- idex_flush  out  1  zero the ID/EX register (insert bubble).

## Operation
- Reset: `pc`=RESET_PC, state RUN, all control outputs 0.
- Load-use hazard (`luh`): `ex_mem_read` && `ex_rd`!=0 && (`ex_rd`==`id_rs1` || `ex_rd`==`id_rs2`).
- Targets are aligned internally: bits [1:0] of `ex_target` are forced to 0 before use.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 gives 0.
- States: RUN, WAIT.
- RUN, `ex_redirect`=1:
  - `ifid_flush`=1 and `idex_flush`=1 combinationally.
  - If `imem_ready`=1: `pc`<=target, stay in RUN.
  - Else: pending<=target, go to WAIT, `pc` holds.
- RUN, no redirect, `luh`=1:
  - `ifid_stall`=1, `idex_flush`=1, `pc` holds.
  - Exactly one bubble per hazard; `luh` clears once the load leaves EX.
- RUN, otherwise: `pc`<=`pc`+4 when `imem_ready`=1, else hold. All controls 0.
- WAIT:
  - `ifid_flush`=1 every cycle, so the stale in-flight fetch is discarded.
  - `luh` is ignored, because ID holds a flushed slot.
  - A new `ex_redirect` overwrites pending (last wins).
  - When `imem_ready`=1: `pc`<=pending, or `ex_target` if a redirect arrives the same cycle; return to RUN.
- Priority: rst > ex_redirect > luh > sequential advance.

## Timing
- Redirect with `imem_ready` high in cycle N: flushes asserted in N, `pc`=target in N+1. Taken-branch penalty is 2 cycles.
- Redirect with `imem_ready` low in N, first `imem_ready` in M: `pc`=target in M+1. `ifid_flush` is high for cycles N..M.
- Load-use detected in N: `pc` and IF/ID frozen through N; dependent instruction enters EX in N+2.
- Reset during WAIT drops the pending target; `pc`=RESET_PC on the next cycle.
- All outputs are glitch-relevant only at the clock edge; the flush/stall outputs are combinational from the current state and inputs.

## Configuration
- `PC_SEQ_PERF_EN` defined: adds 32-bit outputs `stall_cycles` (counts cycles with `luh` acted on) and `redirect_count` (counts accepted redirects; a redirect that overwrites pending counts again).
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent, and functional behaviour is identical.

## Structure
- Shared package `pc_seq_pkg`:
  - state enum {RUN, WAIT}
  - RESET_PC default
  - NOP encoding 32'h0000_0013 used by flushing registers
- Sub-module `load_use_detect`: purely combinational `luh` comparator, reusable by the forwarding unit.
- The FSM, the pending register and the PC register live in the top module.

## Test plan
- Reset, then `imem_ready`=1 for 4 cycles -> `pc` = 0, 4, 8, 12, 16; all control outputs 0.
- `pc`=0x20, `ex_redirect`=1, `ex_target`=0x103, `imem_ready`=1 -> both flushes high that cycle; next `pc`=0x100.
- Redirect to 0x80 with `imem_ready`=0 for 3 cycles, then 1 -> `pc` holds 0x24 throughout, `ifid_flush` high for 4 cycles; `pc`=0x80 after the ready cycle.
- `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5 -> one cycle of `ifid_stall`=1 with `idex_flush`=1, `pc` frozen; `ex_rd`=0 with the same stimulus -> no stall.
- Simultaneous `luh` and redirect -> redirect wins, no stall; second redirect during WAIT to 0x200 -> `pc`=0x200.
- `pc`=0xFFFF_FFFC, advance -> `pc`=0. `rst` asserted in WAIT -> `pc`=RESET_PC, state RUN.
